// File: rtl/mouse_pkt_decoder.sv
// PS/2 stream-mode mouse packet decoder: assembles 3-byte packets and integrates
// signed dx/dy into clamped absolute cursor coordinates plus button levels.
module mouse_pkt_decoder #(
  parameter int unsigned X_MAX   = 1023,
  parameter int unsigned Y_MAX   = 767,
  parameter int unsigned X_INIT  = 512,
  parameter int unsigned Y_INIT  = 384,
  parameter int unsigned TIMEOUT = 130000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_error,
  output logic [11:0] mouse_xpos,
  output logic [11:0] mouse_ypos,
  output logic        mouse_left,
  output logic        mouse_right,
  output logic        pkt_valid
);

  localparam int unsigned PW = 12;
  localparam int unsigned SW = 14;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic signed [SW-1:0] X_MAX_S = SW'(X_MAX);
  localparam logic signed [SW-1:0] Y_MAX_S = SW'(Y_MAX);

  typedef enum logic [1:0] {
    BYTE0 = 2'd0,
    BYTE1 = 2'd1,
    BYTE2 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  // Latched status: {y_ovf, x_ovf, y_sign, x_sign, right, left}
  logic [5:0]      stat_q, stat_d;
  logic [7:0]      dxl_q, dxl_d;
  logic [PW-1:0]   xpos_q, xpos_d;
  logic [PW-1:0]   ypos_q, ypos_d;
  logic            left_q, left_d;
  logic            right_q, right_d;
  logic            pkt_valid_q, pkt_valid_d;

  logic signed [SW-1:0] dx_c, dy_c, nx_c, ny_c;
  logic [PW-1:0]        x_clamp_c, y_clamp_c;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BYTE0;
      timer_q     <= '0;
      stat_q      <= '0;
      dxl_q       <= '0;
      xpos_q      <= PW'(X_INIT);
      ypos_q      <= PW'(Y_INIT);
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      pkt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stat_q      <= stat_d;
      dxl_q       <= dxl_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      left_q      <= left_d;
      right_q     <= right_d;
      pkt_valid_q <= pkt_valid_d;
    end
  end

  // Next-state and mid-packet idle timer
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    if (rx_error) begin
      state_d = BYTE0;
    end else begin
      case (state_q)
        BYTE0: if (rx_valid && rx_data[3]) state_d = BYTE1;
        BYTE1, BYTE2: begin
          if (rx_valid) begin
            state_d = (state_q == BYTE1) ? BYTE2 : BYTE0;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_d = BYTE0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: state_d = BYTE0;
      endcase
    end
  end

  // Signed deltas; dy comes straight from the third byte on the bus
  assign dx_c = {{5{stat_q[2]}}, stat_q[2], dxl_q};
  assign dy_c = {{5{stat_q[3]}}, stat_q[3], rx_data};
  assign nx_c = $signed({2'b00, xpos_q}) + dx_c;
  assign ny_c = $signed({2'b00, ypos_q}) - dy_c;

  assign x_clamp_c = nx_c[SW-1] ? '0 : (nx_c > X_MAX_S) ? PW'(X_MAX) : nx_c[PW-1:0];
  assign y_clamp_c = ny_c[SW-1] ? '0 : (ny_c > Y_MAX_S) ? PW'(Y_MAX) : ny_c[PW-1:0];

  // Byte capture and packet apply
  always_comb begin
    stat_d      = stat_q;
    dxl_d       = dxl_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    left_d      = left_q;
    right_d     = right_q;
    pkt_valid_d = 1'b0;
    if (rx_valid && !rx_error) begin
      case (state_q)
        BYTE0: if (rx_data[3]) stat_d = {rx_data[7:4], rx_data[1:0]};
        BYTE1: dxl_d = rx_data;
        BYTE2: begin
          if (!stat_q[4]) xpos_d = x_clamp_c;
          if (!stat_q[5]) ypos_d = y_clamp_c;
          left_d      = stat_q[0];
          right_d     = stat_q[1];
          pkt_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mouse_xpos  = xpos_q;
  assign mouse_ypos  = ypos_q;
  assign mouse_left  = left_q;
  assign mouse_right = right_q;
  assign pkt_valid   = pkt_valid_q;

endmodule

// File: tb/tb_mouse_pkt_decoder.sv
// Bench for mouse_pkt_decoder: fixed packet table, corner-case sequences and
// random traffic checked against a byte-queue reference model.
module tb_mouse_pkt_decoder;

  localparam int TO   = 40;
  localparam int XMAX = 1023;
  localparam int YMAX = 767;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_error;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic        mouse_left, mouse_right, pkt_valid;

  mouse_pkt_decoder #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .mouse_left(mouse_left),
    .mouse_right(mouse_right), .pkt_valid(pkt_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending bytes of the current packet and cursor state
  logic [7:0] q[$];
  int mx, my, idle;
  logic ml, mr, mpv;

  typedef struct {
    logic [7:0] b0, b1, b2;
    int x, y;
    logic l, r;
  } vec_t;
  vec_t tbl[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    mx = 512; my = 384; ml = 1'b0; mr = 1'b0; mpv = 1'b0; idle = 0;
    q.delete();
  endtask

  task automatic model_apply();
    int dx, dy;
    dx = int'(q[1]) - (q[0][4] ? 256 : 0);
    dy = int'(q[2]) - (q[0][5] ? 256 : 0);
    if (!q[0][6]) mx = clampi(mx + dx, XMAX);
    if (!q[0][7]) my = clampi(my - dy, YMAX);
    ml = q[0][0];
    mr = q[0][1];
    mpv = 1'b1;
    q.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic e);
    mpv = 1'b0;
    if (e) begin
      q.delete();
      idle = 0;
    end else if (v) begin
      idle = 0;
      if (q.size() != 0 || d[3]) begin
        q.push_back(d);
        if (q.size() == 3) model_apply();
      end
    end else if (q.size() != 0) begin
      idle++;
      if (idle == TO) begin
        q.delete();
        idle = 0;
      end
    end
  endtask

  task automatic cmp_model();
    chk("xpos", mouse_xpos, mx);
    chk("ypos", mouse_ypos, my);
    chk("left", mouse_left, ml);
    chk("right", mouse_right, mr);
    chk("pkt_valid", pkt_valid, mpv);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic e);
    @(negedge clk);
    rx_valid = v; rx_data = d; rx_error = e;
    @(posedge clk);
    model_step(v, d, e);
    #1;
    cmp_model();
  endtask

  task automatic send(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    step(1'b1, b0, 1'b0);
    step(1'b1, b1, 1'b0);
    step(1'b1, b2, 1'b0);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int x0, y0;
    tbl[0]  = '{8'h08, 8'h05, 8'h03,  517, 381, 1'b0, 1'b0};
    tbl[1]  = '{8'h39, 8'hF6, 8'hFE,  507, 383, 1'b1, 1'b0};
    tbl[2]  = '{8'h0A, 8'h00, 8'h00,  507, 383, 1'b0, 1'b1};
    tbl[3]  = '{8'h48, 8'hFF, 8'h04,  507, 379, 1'b0, 1'b0};
    tbl[4]  = '{8'h88, 8'h10, 8'hFF,  523, 379, 1'b0, 1'b0};
    tbl[5]  = '{8'h18, 8'h00, 8'hFF,  267, 124, 1'b0, 1'b0};
    tbl[6]  = '{8'h28, 8'hFF, 8'h00,  522, 380, 1'b0, 1'b0};
    tbl[7]  = '{8'h08, 8'hFF, 8'h00,  777, 380, 1'b0, 1'b0};
    tbl[8]  = '{8'h08, 8'hF3, 8'h00, 1020, 380, 1'b0, 1'b0};
    tbl[9]  = '{8'h08, 8'h10, 8'h00, 1023, 380, 1'b0, 1'b0};
    tbl[10] = '{8'h08, 8'h7F, 8'h00, 1023, 380, 1'b0, 1'b0};
    tbl[11] = '{8'h08, 8'h00, 8'hFF, 1023, 125, 1'b0, 1'b0};
    tbl[12] = '{8'h08, 8'h00, 8'h78, 1023,   5, 1'b0, 1'b0};
    tbl[13] = '{8'h08, 8'h00, 8'h20, 1023,   0, 1'b0, 1'b0};
    tbl[14] = '{8'h28, 8'h00, 8'h00, 1023, 256, 1'b0, 1'b0};
    tbl[15] = '{8'h18, 8'h00, 8'h00,  767, 256, 1'b0, 1'b0};
    tbl[16] = '{8'h18, 8'h00, 8'h00,  511, 256, 1'b0, 1'b0};
    tbl[17] = '{8'h18, 8'h00, 8'h00,  255, 256, 1'b0, 1'b0};
    tbl[18] = '{8'h18, 8'h00, 8'h00,    0, 256, 1'b0, 1'b0};
    tbl[19] = '{8'h28, 8'h00, 8'h00,    0, 512, 1'b0, 1'b0};
    tbl[20] = '{8'h28, 8'h00, 8'h00,    0, 767, 1'b0, 1'b0};
    tbl[21] = '{8'h0B, 8'h00, 8'h00,    0, 767, 1'b1, 1'b1};
    tbl[22] = '{8'hC8, 8'h80, 8'h80,    0, 767, 1'b0, 1'b0};

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_error = 1'b0;
    model_reset();
    #12;
    chk("rst_xpos", mouse_xpos, 512);
    chk("rst_ypos", mouse_ypos, 384);
    chk("rst_left", mouse_left, 0);
    chk("rst_right", mouse_right, 0);
    chk("rst_pkt_valid", pkt_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back packets from the table, cumulative from reset
    for (int i = 0; i < 23; i++) begin
      send(tbl[i].b0, tbl[i].b1, tbl[i].b2);
      chk($sformatf("tbl%0d_x", i), mouse_xpos, tbl[i].x);
      chk($sformatf("tbl%0d_y", i), mouse_ypos, tbl[i].y);
      chk($sformatf("tbl%0d_l", i), mouse_left, tbl[i].l);
      chk($sformatf("tbl%0d_r", i), mouse_right, tbl[i].r);
      chk($sformatf("tbl%0d_pv", i), pkt_valid, 1);
    end
    idle_n(2);
    chk("pv_one_cycle", pkt_valid, 0);

    send(8'h18, 8'h00, 8'h00);  // x stays 0 via negative clamp
    send(8'h08, 8'h80, 8'h40);  // x=128, y=703
    x0 = 128; y0 = 703;

    // Stray byte without sync bit is dropped
    step(1'b1, 8'h05, 1'b0);
    chk("stray_pv", pkt_valid, 0);
    send(8'h08, 8'h01, 8'h01);
    chk("stray_x", mouse_xpos, x0 + 1);
    chk("stray_y", mouse_ypos, y0 - 1);

    // Timeout drops the partial packet
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    idle_n(TO);
    send(8'h08, 8'h02, 8'h02);
    chk("timeout_x", mouse_xpos, x0 + 3);
    chk("timeout_y", mouse_ypos, y0 - 3);

    // Gap just under the timeout keeps the packet alive
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    idle_n(TO - 2);
    step(1'b1, 8'h03, 1'b0);
    chk("near_to_x", mouse_xpos, x0 + 4);
    chk("near_to_y", mouse_ypos, y0 - 6);
    chk("near_to_pv", pkt_valid, 1);

    // Error with valid on byte1, then a lone error on byte2
    step(1'b1, 8'h09, 1'b0);
    step(1'b1, 8'h05, 1'b1);
    step(1'b1, 8'h05, 1'b0);
    chk("err_pv", pkt_valid, 0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    send(8'h08, 8'h01, 8'h01);
    chk("err_x", mouse_xpos, x0 + 5);
    chk("err_y", mouse_ypos, y0 - 7);
    chk("err_left", mouse_left, 0);

    // Asynchronous reset in the middle of a packet
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_x", mouse_xpos, 512);
    chk("arst_y", mouse_ypos, 384);
    @(negedge clk);
    rst = 1'b0;
    send(8'h08, 8'h05, 8'h03);
    chk("post_rst_x", mouse_xpos, 517);
    chk("post_rst_y", mouse_ypos, 381);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic v, e;
      logic [7:0] d;
      v = ($urandom % 3) != 0;
      e = ($urandom % 50) == 0;
      d = 8'($urandom);
      if (($urandom % 4) == 0) d[3] = 1'b1;
      step(v, d, e);
      if (($urandom % 300) == 0) idle_n(TO + 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
